// File: rtl/bcd_time_keeper.sv
// BCD mm:ss wall-clock counter with prescaler, validated time load and a held
// alarm-ring flag that is cleared by acknowledge or by disabling the alarm.
module bcd_time_keeper #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        run,
  input  logic        load_valid,
  input  logic [15:0] load_time,
  input  logic [15:0] alarm_time,
  input  logic        alarm_en,
  input  logic        alarm_ack,
  output logic [15:0] current_time,
  output logic        sec_tick,
  output logic        wrap,
  output logic        load_err,
  output logic        alarm_ring
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RING = 1'b1;

  logic [15:0]   r_time;
  logic [PW-1:0] r_presc;
  logic [0:0]    r_state;
  logic          r_sec_tick;
  logic          r_wrap;
  logic          r_load_err;

  logic [15:0]   w_time_nxt;
  logic [15:0]   w_time_inc;
  logic [PW-1:0] w_presc_nxt;
  logic [0:0]    w_state_nxt;
  logic          w_sec_tick_nxt;
  logic          w_wrap_nxt;
  logic          w_load_err_nxt;
  logic          w_load_ok;
  logic          w_tick;
  logic          w_match;

  // One-second BCD increment with carries s0 -> s1 -> m0 -> m1, wrapping at 59:59.
  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = t;
    if (s0 != 4'd9) begin
      s0 = s0 + 4'd1;
    end else begin
      s0 = 4'd0;
      if (s1 != 4'd5) begin
        s1 = s1 + 4'd1;
      end else begin
        s1 = 4'd0;
        if (m0 != 4'd9) begin
          m0 = m0 + 4'd1;
        end else begin
          m0 = 4'd0;
          m1 = (m1 == 4'd5) ? 4'd0 : m1 + 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  assign w_load_ok = (load_time[15:12] <= 4'd5) && (load_time[11:8] <= 4'd9) &&
                     (load_time[7:4]   <= 4'd5) && (load_time[3:0]  <= 4'd9);
  assign w_tick     = run && (r_presc == PRESC_MAX);
  assign w_time_inc = bcd_inc(r_time);

  // Next-state: a valid load overrides the tick; a tick match overrides acknowledge.
  always_comb begin
    w_time_nxt     = r_time;
    w_presc_nxt    = r_presc;
    w_state_nxt    = r_state;
    w_sec_tick_nxt = 1'b0;
    w_wrap_nxt     = 1'b0;
    w_load_err_nxt = load_valid && !w_load_ok;
    w_match        = 1'b0;

    if (load_valid && w_load_ok) begin
      w_time_nxt  = load_time;
      w_presc_nxt = '0;
    end else if (run) begin
      if (w_tick) begin
        w_presc_nxt    = '0;
        w_time_nxt     = w_time_inc;
        w_sec_tick_nxt = 1'b1;
        w_wrap_nxt     = (r_time == 16'h5959);
        w_match        = (w_time_inc == alarm_time);
      end else begin
        w_presc_nxt = r_presc + PW'(1);
      end
    end

    case (r_state)
      S_IDLE: if (alarm_en && w_match) w_state_nxt = S_RING;
      S_RING: if (!alarm_en || (alarm_ack && !w_match)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_time     <= 16'h0000;
      r_presc    <= '0;
      r_state    <= S_IDLE;
      r_sec_tick <= 1'b0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_time     <= w_time_nxt;
      r_presc    <= w_presc_nxt;
      r_state    <= w_state_nxt;
      r_sec_tick <= w_sec_tick_nxt;
      r_wrap     <= w_wrap_nxt;
      r_load_err <= w_load_err_nxt;
    end
  end

  assign current_time = r_time;
  assign sec_tick     = r_sec_tick;
  assign wrap         = r_wrap;
  assign load_err     = r_load_err;
  assign alarm_ring   = (r_state == S_RING);

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Directed and randomized checks of bcd_time_keeper against a seconds-based
// reference model (time kept as an integer 0..3599, converted to BCD for compare).
module tb_bcd_time_keeper;

  logic        clk = 1'b0;
  logic        resetn;
  logic        run;
  logic        load_valid;
  logic [15:0] load_time;
  logic [15:0] alarm_time;
  logic        alarm_en;
  logic        alarm_ack;
  logic [15:0] current_time;
  logic        sec_tick;
  logic        wrap;
  logic        load_err;
  logic        alarm_ring;

  int n_total = 0;
  int n_pass  = 0;

  // reference model state
  int m_secs = 0;
  int m_cnt  = 0;
  bit m_tick = 0;
  bit m_wrap = 0;
  bit m_err  = 0;
  bit m_ring = 0;

  bcd_time_keeper #(.TICK_DIV(4)) dut (
    .clk(clk), .resetn(resetn), .run(run), .load_valid(load_valid),
    .load_time(load_time), .alarm_time(alarm_time), .alarm_en(alarm_en),
    .alarm_ack(alarm_ack), .current_time(current_time), .sec_tick(sec_tick),
    .wrap(wrap), .load_err(load_err), .alarm_ring(alarm_ring)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] to_bcd(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    m_secs = 0; m_cnt = 0; m_tick = 0; m_wrap = 0; m_err = 0; m_ring = 0;
  endtask

  // Apply the rules for one rising edge using the inputs sampled at that edge.
  task automatic model_edge();
    int d3, d2, d1, d0;
    bit valid, match;
    if (!resetn) begin
      model_reset();
      return;
    end
    d3 = int'(load_time[15:12]); d2 = int'(load_time[11:8]);
    d1 = int'(load_time[7:4]);   d0 = int'(load_time[3:0]);
    valid  = load_valid && d3 <= 5 && d2 <= 9 && d1 <= 5 && d0 <= 9;
    m_err  = load_valid && !valid;
    m_tick = 0;
    m_wrap = 0;
    match  = 0;
    if (valid) begin
      m_secs = (d3 * 10 + d2) * 60 + d1 * 10 + d0;
      m_cnt  = 0;
    end else if (run) begin
      if (m_cnt == 3) begin
        m_cnt  = 0;
        m_secs = (m_secs + 1) % 3600;
        m_tick = 1;
        m_wrap = (m_secs == 0);
        match  = (to_bcd(m_secs) == alarm_time);
      end else begin
        m_cnt++;
      end
    end
    if (!alarm_en)  m_ring = 0;
    else if (match) m_ring = 1;
    else if (alarm_ack) m_ring = 0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/time"}, current_time, to_bcd(m_secs));
    chk({tag, "/tick"}, 16'(sec_tick),   16'(m_tick));
    chk({tag, "/wrap"}, 16'(wrap),       16'(m_wrap));
    chk({tag, "/err"},  16'(load_err),   16'(m_err));
    chk({tag, "/ring"}, 16'(alarm_ring), 16'(m_ring));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    load_valid = 1'b0;
    alarm_ack  = 1'b0;
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic do_load(input string tag, input logic [15:0] t);
    load_valid = 1'b1;
    load_time  = t;
    step(tag);
  endtask

  initial begin
    resetn = 1'b0; run = 1'b0; load_valid = 1'b0; load_time = 16'h0000;
    alarm_time = 16'h0000; alarm_en = 1'b0; alarm_ack = 1'b0;
    model_reset();
    steps("reset", 2);
    resetn = 1'b1;

    // basic counting and hold
    run = 1'b1;
    steps("count", 9);
    run = 1'b0;
    steps("hold", 5);
    run = 1'b1;
    steps("resume", 4);

    // carries and wrap
    do_load("ld0959", 16'h0959);
    steps("carry", 4);
    do_load("ld5959", 16'h5959);
    steps("wrap", 5);

    // invalid loads while held, then a valid one
    run = 1'b0;
    do_load("bad6000", 16'h6000);
    do_load("bad000A", 16'h000A);
    do_load("bad0A00", 16'h0A00);
    do_load("ok5959", 16'h5959);
    do_load("b2b_a", 16'h1234);
    do_load("b2b_b", 16'h0A11);
    step("b2b_hold");

    // alarm ring and acknowledge
    alarm_time = 16'h0003; alarm_en = 1'b1; run = 1'b1;
    do_load("al_ld0", 16'h0000);
    steps("al_run", 20);
    alarm_ack = 1'b1;
    step("al_ack");
    steps("al_after", 2);
    do_load("al_ld3", 16'h0003);
    steps("al_noring", 3);
    alarm_en = 1'b0;
    do_load("al_dis0", 16'h0000);
    steps("al_dis", 16);

    // load on a tick edge wins over the tick
    for (int i = 0; i < 8; i++) begin
      if (m_cnt == 3) break;
      step("col_wait");
    end
    do_load("col_ld", 16'h0200);
    steps("col_next", 4);

    // acknowledge on the matching tick keeps ringing
    alarm_en = 1'b1; alarm_time = 16'h0202;
    for (int i = 0; i < 8; i++) begin
      if (m_cnt == 3) break;
      step("ack_wait");
    end
    alarm_ack = 1'b1;
    step("ack_match");
    steps("ack_hold", 2);

    // asynchronous reset while ringing at 0003
    alarm_time = 16'h0003;
    do_load("ar_ld", 16'h0000);
    steps("ar_run", 12);
    #3;
    resetn = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    step("rst_hold");
    resetn = 1'b1;
    steps("rst_rel", 5);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      run       = ($urandom_range(0, 9) != 0);
      alarm_en  = ($urandom_range(0, 9) != 0);
      alarm_ack = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0)
        alarm_time = to_bcd((m_secs + int'($urandom_range(1, 3))) % 3600);
      if ($urandom_range(0, 49) == 0) begin
        load_valid = 1'b1;
        load_time  = 16'h5959;
      end else if ($urandom_range(0, 9) == 0) begin
        load_valid = 1'b1;
        load_time  = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 10)),
                      4'($urandom_range(0, 7)), 4'($urandom_range(0, 10))};
      end
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
